fp_div_seq: RTL
===============

Name: fp_div_seq

Overview:
- Sequential IEEE-754 single-precision divider that computes fp_Z = fp_X / fp_Y.
- Inverse operation to the FPU multiplier; shares its operand format, r_mode encoding, ovrf/udrf flags and flush-to-zero subnormal policy.
- Uses a radix-2 restoring mantissa divider (one quotient bit per cycle) driven by an FSM with a start/busy/done handshake.
- Sits in the ALU beside the multiplier.

Parameters:
- ITER, 26, quotient bits produced in DIVIDE (24 significand + guard + 1 normalisation bit); sticky bit is taken from the final remainder.
- CANON_NAN, 32'h7FC00000, NaN pattern returned for every invalid case.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- fp_X  input  32  dividend, captured on accepted start
- fp_Y  input  32  divisor, captured on accepted start
- r_mode  input  3  rounding mode, captured on accepted start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the result becomes valid
- fp_Z  output  32  quotient; held until the next accepted start
- ovrf  output  1  overflow flag; valid with done, held like fp_Z
- udrf  output  1  underflow flag; valid with done, held like fp_Z

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state=IDLE, busy=0, done=0, fp_Z=0, ovrf=0, udrf=0.
  - rst in any state aborts the operation in progress on the same edge. No done is produced for it.
- FSM states: IDLE, UNPACK, DIVIDE, ROUND, DONE.
  - IDLE: start=1 captures fp_X, fp_Y, r_mode and moves to UNPACK.
  - start is ignored in every other state (no queuing).
  - UNPACK (1 cycle): classify operands.
    - Exponent 0 counts as zero; the fraction is ignored (flush-to-zero).
    - Exponent FF with fraction 0 is inf; exponent FF with nonzero fraction is NaN.
    - Special case → DONE directly. Otherwise load the mantissas, set exponent = eX - eY + 127 (10-bit signed), then → DIVIDE.
  - DIVIDE (ITER cycles): restoring step per cycle.
    - Compare the remainder with 1.mY; subtract if greater or equal; shift a quotient bit in.
    - An iteration counter counts 0..ITER-1, then → ROUND.
  - ROUND (1 cycle):
    - If the quotient MSB is 0, shift left by 1 and decrement the exponent.
    - Form guard and sticky (sticky = remainder != 0), then apply r_mode.
    - Mantissa carry-out from rounding increments the exponent.
    - Then → DONE.
  - DONE (1 cycle): done=1, outputs updated, then → IDLE.
- Latency:
  - Normal path: start sampled at edge k, done high in cycle k+29 (1 UNPACK + 26 DIVIDE + 1 ROUND + DONE).
  - Special path: done high in cycle k+2.
  - A new start is accepted in the IDLE cycle following DONE.
- Result sign is always sX XOR sY, including zeros and infinities. NaN output is CANON_NAN.
- Special cases:
  - NaN operand, 0/0 or inf/inf → CANON_NAN.
  - x/0 with x≠0 → inf; inf/finite → inf; finite/inf → zero; 0/finite → zero.
  - ovrf=udrf=0 on every special case, including subnormal inputs flushed to zero.
- r_mode encoding: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM. Codes 101–111 behave as RNE.
- Overflow (final exponent ≥ 255): ovrf=1.
  - Result is inf for RNE and RMM, for RUP when positive, and for RDN when negative.
  - Otherwise the result is max finite 0x7F7FFFFF with the result sign.
- Underflow (final exponent ≤ 0 after rounding): fp_Z = signed zero, udrf=1. No subnormal outputs are produced.

Test Plan:
- 0x40C00000 / 0x40000000, RNE → done at k+29, fp_Z=0x40400000, ovrf=udrf=0; busy high from k+1 to k+29.
- 0x3F800000 / 0x40400000 → RNE 0x3EAAAAAB; RTZ 0x3EAAAAAA; RUP 0x3EAAAAAB; RDN 0x3EAAAAAA.
- Specials, each with done at k+2 and no flags:
  - 0x3F800000 / 0x00000000 → 0x7F800000.
  - 0x80000000 / 0x00000000 → 0x7FC00000.
  - 0x00400000 / 0x3F800000 → 0x00000000.
- 0x7F7FFFFF / 0x3F000000 → RNE 0x7F800000 with ovrf=1; RTZ 0x7F7FFFFF with ovrf=1. Second start pulsed mid-operation is ignored.
- 0x00800000 / 0x40000000 → 0x00000000 with udrf=1; 0x80800000 / 0x40000000 → 0x80000000 with udrf=1.
- Assert rst at DIVIDE cycle 10 → next cycle busy=0, done=0, fp_Z=0. A fresh start then completes normally with the correct result.

Source files
------------

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider (fp_Z = fp_X / fp_Y).
// Radix-2 restoring mantissa divider; subnormals are flushed to zero.
module fp_div_seq #(
    parameter int          ITER      = 26,
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    input  logic [2:0]  r_mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf
);

    localparam int CW = $clog2(ITER);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_DIVIDE = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [31:0]       x_q, x_d;
    logic [31:0]       y_q, y_d;
    logic [2:0]        rmode_q, rmode_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [23:0]       div_q, div_d;
    logic [24:0]       rem_q, rem_d;
    logic [ITER-1:0]   quo_q, quo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       z_q, z_d;
    logic              ovrf_q, ovrf_d;
    logic              udrf_q, udrf_d;

    // Operand classification
    logic        zero_x, zero_y, inf_x, inf_y, nan_x, nan_y;
    logic        is_nan, is_special, sign_xy;
    logic [31:0] special_z;

    always_comb begin
        zero_x     = (x_q[30:23] == 8'h00);
        zero_y     = (y_q[30:23] == 8'h00);
        inf_x      = (x_q[30:23] == 8'hFF) && (x_q[22:0] == 23'd0);
        inf_y      = (y_q[30:23] == 8'hFF) && (y_q[22:0] == 23'd0);
        nan_x      = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
        nan_y      = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);
        sign_xy    = x_q[31] ^ y_q[31];
        is_nan     = nan_x || nan_y || (zero_x && zero_y) || (inf_x && inf_y);
        is_special = is_nan || zero_x || zero_y || inf_x || inf_y;
        if (is_nan) begin
            special_z = CANON_NAN;
        end else if (inf_x || zero_y) begin
            special_z = {sign_xy, 8'hFF, 23'd0};
        end else begin
            special_z = {sign_xy, 31'd0};
        end
    end

    // Normalisation, rounding and range checks on the finished quotient
    logic [ITER-1:0]   norm;
    logic signed [9:0] exp_n, exp_r;
    logic [23:0]       mant;
    logic [24:0]       mant_r;
    logic [22:0]       frac_r;
    logic              guard, sticky, inc, to_inf, ovf, unf;
    logic [31:0]       round_z;

    always_comb begin
        norm   = quo_q[ITER-1] ? quo_q : {quo_q[ITER-2:0], 1'b0};
        exp_n  = quo_q[ITER-1] ? exp_q : exp_q - 10'sd1;
        mant   = norm[ITER-1 -: 24];
        guard  = norm[ITER-25];
        sticky = (|norm[ITER-26:0]) || (rem_q != 25'd0);
        case (rmode_q)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_q & (guard | sticky);
            3'b011:  inc = ~sign_q & (guard | sticky);
            3'b100:  inc = guard;
            default: inc = guard & (sticky | mant[0]);
        endcase
        case (rmode_q)
            3'b001:  to_inf = 1'b0;
            3'b010:  to_inf = sign_q;
            3'b011:  to_inf = ~sign_q;
            default: to_inf = 1'b1;
        endcase
        mant_r = {1'b0, mant} + {24'd0, inc};
        exp_r  = mant_r[24] ? exp_n + 10'sd1 : exp_n;
        frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        ovf    = (exp_r >= 10'sd255);
        unf    = (exp_r <= 10'sd0);
        if (ovf) begin
            round_z = to_inf ? {sign_q, 8'hFF, 23'd0} : {sign_q, 8'hFE, 23'h7FFFFF};
        end else if (unf) begin
            round_z = {sign_q, 31'd0};
        end else begin
            round_z = {sign_q, exp_r[7:0], frac_r};
        end
    end

    logic        sub_ok;
    logic [23:0] diff;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        rmode_d = rmode_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        ovrf_d  = ovrf_q;
        udrf_d  = udrf_q;
        sub_ok  = (rem_q >= {1'b0, div_q});
        diff    = sub_ok ? 24'(rem_q - {1'b0, div_q}) : rem_q[23:0];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = fp_X;
                    y_d     = fp_Y;
                    rmode_d = r_mode;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d = sign_xy;
                if (is_special) begin
                    z_d     = special_z;
                    ovrf_d  = 1'b0;
                    udrf_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    rem_d   = {2'b01, x_q[22:0]};
                    div_d   = {1'b1, y_q[22:0]};
                    exp_d   = $signed({2'b00, x_q[30:23]}) - $signed({2'b00, y_q[30:23]}) + 10'sd127;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                rem_d = {diff, 1'b0};
                quo_d = {quo_q[ITER-2:0], sub_ok};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                z_d     = round_z;
                ovrf_d  = ovf;
                udrf_d  = unf && !ovf;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            rmode_q <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            ovrf_q  <= 1'b0;
            udrf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rmode_q <= rmode_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            ovrf_q  <= ovrf_d;
            udrf_q  <= udrf_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign fp_Z = z_q;
    assign ovrf = ovrf_q;
    assign udrf = udrf_q;

endmodule
